// File: rtl/soc_system_dpram_pkg.sv
// Shared types, constants and the byte-merge helper for the dual-port Avalon-MM RAM.
package soc_system_dpram_pkg;

  typedef logic [0:0] state_t;
  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_RUN   = 1'b1;

  localparam int unsigned READ_LATENCY_MIN = 1;
  localparam int unsigned READ_LATENCY_MAX = 2;

  // Widest word the merge helper handles; callers zero-extend and truncate around it.
  localparam int unsigned MERGE_W    = 1024;
  localparam int unsigned MERGE_BE_W = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] byte_merge(input logic [MERGE_W-1:0]    old_word,
                                                    input logic [MERGE_W-1:0]    new_word,
                                                    input logic [MERGE_BE_W-1:0] be);
    logic [MERGE_W-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(MERGE_BE_W); i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/soc_system_dpram_rdpipe.sv
// Read-return pipeline: LATENCY stages of data/valid, each data stage loads only with its valid,
// so the output word holds between strobes.
module soc_system_dpram_rdpipe #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [DATA_W-1:0]  dat_q   [LATENCY];
  logic [DATA_W-1:0]  dat_d   [LATENCY];
  logic [DATA_W-1:0]  dat_in  [LATENCY];

  always_comb begin
    vld_d     = LATENCY'({vld_q, valid_i});
    dat_in[0] = data_i;
    for (int i = 1; i < int'(LATENCY); i++) begin
      dat_in[i] = dat_q[i-1];
    end
    for (int i = 0; i < int'(LATENCY); i++) begin
      dat_d[i] = vld_d[i] ? dat_in[i] : dat_q[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < int'(LATENCY); i++) dat_q[i] <= dat_d[i];
    end
  end

  assign valid_o = vld_q[LATENCY-1];
  assign data_o  = dat_q[LATENCY-1];

endmodule

// File: rtl/soc_system_dpram_avmm.sv
// True dual-port RAM with two Avalon-MM slaves on one clock.
// Define SOC_SYSTEM_DPRAM_CLEAR_EN to build the post-reset zero-fill engine.
module soc_system_dpram_avmm
  import soc_system_dpram_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if (DATA_W % 8 != 0 || DATA_W > MERGE_W) begin : g_bad_width
    $error("DATA_W must be a multiple of 8 no wider than MERGE_W");
  end

  function automatic logic [DATA_W-1:0] merge_be(input logic [DATA_W-1:0] old_word,
                                                 input logic [DATA_W-1:0] new_word,
                                                 input logic [BE_W-1:0]   be);
    return DATA_W'(byte_merge(MERGE_W'(old_word), MERGE_W'(new_word), MERGE_BE_W'(be)));
  endfunction

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

`ifdef SOC_SYSTEM_DPRAM_CLEAR_EN
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == ST_CLEAR) begin
      clr_addr_d = clr_addr_q + ADDR_W'(1);
      if (clr_addr_q == {ADDR_W{1'b1}}) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = clr_addr_q;
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  assign s1_waitrequest = busy;
  assign s2_waitrequest = busy;

  logic s1_acc, s2_acc, s1_wr, s2_wr, s1_rd, s2_rd, collide;

  // A simultaneous read+write is a write only.
  assign s1_acc  = s1_chipselect & ~busy;
  assign s2_acc  = s2_chipselect & ~busy;
  assign s1_wr   = s1_acc & s1_write;
  assign s2_wr   = s2_acc & s2_write;
  assign s1_rd   = s1_acc & s1_read & ~s1_write;
  assign s2_rd   = s2_acc & s2_read & ~s2_write;
  assign collide = s1_wr & s2_wr & (s1_address == s2_address);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] s1_wword, s2_wword, col_wword;

  // On a collision s2 is merged first so s1 wins every byte it enables.
  always_comb begin
    s1_wword  = merge_be(mem_q[s1_address], s1_writedata, s1_byteenable);
    s2_wword  = merge_be(mem_q[s2_address], s2_writedata, s2_byteenable);
    col_wword = merge_be(s2_wword, s1_writedata, s1_byteenable);
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (collide) begin
      mem_q[s1_address] <= col_wword;
    end else begin
      if (s1_wr) mem_q[s1_address] <= s1_wword;
      if (s2_wr) mem_q[s2_address] <= s2_wword;
    end
  end

  // Reads sample the array before this cycle's writes land, giving read-before-write.
  soc_system_dpram_rdpipe #(
    .DATA_W  (DATA_W),
    .LATENCY (READ_LATENCY)
  ) u_rdpipe_s1 (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .valid_i (s1_rd),
    .data_i  (mem_q[s1_address]),
    .valid_o (s1_readdatavalid),
    .data_o  (s1_readdata)
  );

  soc_system_dpram_rdpipe #(
    .DATA_W  (DATA_W),
    .LATENCY (READ_LATENCY)
  ) u_rdpipe_s2 (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .valid_i (s2_rd),
    .data_i  (mem_q[s2_address]),
    .valid_o (s2_readdatavalid),
    .data_o  (s2_readdata)
  );

endmodule

// File: tb/tb_soc_system_dpram_avmm.sv
// Self-checking bench for soc_system_dpram_avmm: directed cases plus random dual-port traffic
// checked against an array/queue reference model.
module tb_soc_system_dpram_avmm;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 6;
  localparam int unsigned RL    = 2;
  localparam int unsigned BW    = DW / 8;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef SOC_SYSTEM_DPRAM_CLEAR_EN
  localparam int CLR_CYCLES = DEPTH;
`else
  localparam int CLR_CYCLES = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] s1_address, s2_address;
  logic          s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [BW-1:0] s1_byteenable, s2_byteenable;
  logic [DW-1:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
  logic          s1_readdatavalid, s1_waitrequest, s2_readdatavalid, s2_waitrequest;

  always #5 clk = ~clk;

  soc_system_dpram_avmm #(
    .DATA_W       (DW),
    .ADDR_W       (AW),
    .READ_LATENCY (RL)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .s1_address       (s1_address),
    .s1_chipselect    (s1_chipselect),
    .s1_read          (s1_read),
    .s1_write         (s1_write),
    .s1_byteenable    (s1_byteenable),
    .s1_writedata     (s1_writedata),
    .s1_readdata      (s1_readdata),
    .s1_readdatavalid (s1_readdatavalid),
    .s1_waitrequest   (s1_waitrequest),
    .s2_address       (s2_address),
    .s2_chipselect    (s2_chipselect),
    .s2_read          (s2_read),
    .s2_write         (s2_write),
    .s2_byteenable    (s2_byteenable),
    .s2_writedata     (s2_writedata),
    .s2_readdata      (s2_readdata),
    .s2_readdatavalid (s2_readdatavalid),
    .s2_waitrequest   (s2_waitrequest)
  );

  typedef struct {
    logic          cs;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
  } cmd_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] model [DEPTH];
  rd_t           q1[$];
  rd_t           q2[$];
  logic [DW-1:0] last1 = '0;
  logic [DW-1:0] last2 = '0;
  int            tick = 0;
  int            clr_left = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  function automatic cmd_t mk(input logic cs, input logic rd, input logic wr,
                              input logic [AW-1:0] a, input logic [BW-1:0] be,
                              input logic [DW-1:0] d);
    cmd_t c;
    c.cs = cs; c.rd = rd; c.wr = wr; c.addr = a; c.be = be; c.wd = d;
    return c;
  endfunction

  function automatic cmd_t idle();
    return mk(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endfunction

  function automatic cmd_t wr(input logic [AW-1:0] a, input logic [BW-1:0] be,
                              input logic [DW-1:0] d);
    return mk(1'b1, 1'b0, 1'b1, a, be, d);
  endfunction

  function automatic cmd_t rd(input logic [AW-1:0] a);
    return mk(1'b1, 1'b1, 1'b0, a, '0, '0);
  endfunction

  function automatic logic [DW-1:0] apply_be(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                             input logic [BW-1:0] be);
    logic [DW-1:0] r;
    for (int b = 0; b < int'(BW); b++) begin
      r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input cmd_t c1, input cmd_t c2);
    s1_chipselect = c1.cs; s1_read = c1.rd; s1_write = c1.wr;
    s1_address = c1.addr; s1_byteenable = c1.be; s1_writedata = c1.wd;
    s2_chipselect = c2.cs; s2_read = c2.rd; s2_write = c2.wr;
    s2_address = c2.addr; s2_byteenable = c2.be; s2_writedata = c2.wd;
  endtask

  task automatic check_outputs();
    logic v1, v2;
    v1 = (q1.size() > 0) && (q1[0].due == tick);
    v2 = (q2.size() > 0) && (q2[0].due == tick);
    if (v1) begin last1 = q1[0].data; void'(q1.pop_front()); end
    if (v2) begin last2 = q2[0].data; void'(q2.pop_front()); end
    chk("s1_readdatavalid", DW'(s1_readdatavalid), DW'(v1));
    chk("s2_readdatavalid", DW'(s2_readdatavalid), DW'(v2));
    chk("s1_readdata", s1_readdata, last1);
    chk("s2_readdata", s2_readdata, last2);
    chk("s1_waitrequest", DW'(s1_waitrequest), DW'(clr_left > 0));
    chk("s2_waitrequest", DW'(s2_waitrequest), DW'(clr_left > 0));
  endtask

  // One clock: drive, let the edge accept, update the model, then check.
  task automatic step(input cmd_t c1, input cmd_t c2);
    logic stalled, a1, a2;
    drive(c1, c2);
    stalled = (clr_left > 0);
    @(posedge clk);
    tick++;
    a1 = c1.cs && !stalled;
    a2 = c2.cs && !stalled;
    if (a1 && c1.rd && !c1.wr) q1.push_back('{due: tick + int'(RL) - 1, data: model[c1.addr]});
    if (a2 && c2.rd && !c2.wr) q2.push_back('{due: tick + int'(RL) - 1, data: model[c2.addr]});
    if (a2 && c2.wr) model[c2.addr] = apply_be(model[c2.addr], c2.wd, c2.be);
    if (a1 && c1.wr) model[c1.addr] = apply_be(model[c1.addr], c1.wd, c1.be);
    if (clr_left > 0) clr_left--;
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    drive(idle(), idle());
    #1 reset_n = 1'b0;
    #1;
    q1.delete();
    q2.delete();
    last1 = '0;
    last2 = '0;
    clr_left = CLR_CYCLES;
`ifdef SOC_SYSTEM_DPRAM_CLEAR_EN
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
`endif
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_outputs();
  endtask

  task automatic wait_ready();
    while (clr_left > 0) step(idle(), idle());
  endtask

  initial begin
    cmd_t c1, c2;
    drive(idle(), idle());

    do_reset();
    wait_ready();

`ifdef SOC_SYSTEM_DPRAM_CLEAR_EN
    for (int i = 0; i < int'(DEPTH); i++) begin
      step(rd(AW'(i)), rd(AW'(DEPTH - 1 - i)));
    end
    repeat (RL) step(idle(), idle());
`endif

    // Give every word a known value so later reads are defined.
    for (int i = 0; i < int'(DEPTH); i++) begin
      step(wr(AW'(i), '1, DW'($urandom)), idle());
    end

    // s1 write then s2 read next cycle
    step(wr(AW'('h10), '1, 32'h0000_00A5), idle());
    step(idle(), rd(AW'('h10)));
    repeat (RL) step(idle(), idle());
    chk("a5_cross_port", s2_readdata, 32'h0000_00A5);

    // partial byte enables
    step(wr(AW'(5), 4'hF, 32'h1122_3344), idle());
    step(wr(AW'(5), 4'b0101, 32'hAABB_CCDD), idle());
    step(rd(AW'(5)), idle());
    repeat (RL) step(idle(), idle());
    chk("byteenable_merge", s1_readdata, 32'h11BB_33DD);

    // same-cycle write collision
    step(wr(AW'(7), 4'b1100, 32'hFFFF_0000), wr(AW'(7), 4'b0111, 32'h1234_5678));
    step(idle(), rd(AW'(7)));
    repeat (RL) step(idle(), idle());
    chk("write_collision", s2_readdata, 32'hFFFF_5678);

    // cross-port read-during-write returns old data
    step(wr(AW'('h20), '1, '0), idle());
    step(wr(AW'('h20), '1, 32'h0000_003C), rd(AW'('h20)));
    repeat (RL) step(idle(), idle());
    chk("rdw_old_data", s2_readdata, 32'h0000_0000);
    step(idle(), rd(AW'('h20)));
    repeat (RL) step(idle(), idle());
    chk("rdw_new_data", s2_readdata, 32'h0000_003C);

    // read+write together is a write only; back-to-back reads then stream
    step(mk(1'b1, 1'b1, 1'b1, AW'(9), '1, 32'hDEAD_BEEF), idle());
    for (int i = 0; i < 8; i++) step(rd(AW'(i + 4)), rd(AW'(i + 2)));
    repeat (RL) step(idle(), idle());

    // random traffic, narrow address range to provoke collisions
    for (int n = 0; n < 600; n++) begin
      c1 = mk(($urandom_range(9) < 8), $urandom_range(1), $urandom_range(1),
              AW'($urandom_range(7)), BW'($urandom), DW'($urandom));
      c2 = mk(($urandom_range(9) < 8), $urandom_range(1), $urandom_range(1),
              AW'($urandom_range(7)), BW'($urandom), DW'($urandom));
      if ($urandom_range(3) == 0) c1.addr = AW'($urandom);
      step(c1, c2);
    end
    repeat (RL) step(idle(), idle());

    // reset while a read is in flight
    step(rd(AW'(3)), rd(AW'(4)));
    do_reset();
    chk("abort_s1_readdata", s1_readdata, '0);
    chk("abort_s2_readdata", s2_readdata, '0);
    repeat (RL + 1) step(idle(), idle());
    wait_ready();
    step(rd(AW'('h20)), rd(AW'(5)));
    repeat (RL + 1) step(idle(), idle());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
